// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
// The up/down direction type is only used when PWM_CENTER_ALIGN_EN is defined.
package pwm_pkg;

   typedef enum logic {CNT_UP, CNT_DOWN} cnt_dir_t;

   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic logic idle_level(input int active_low);
      return logic'(active_low != 0);
   endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: shadow/active duty pair, unsigned compare against the shared
// counter, and the registered output pin.
module pwm_channel_cmp
   import pwm_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int ACTIVE_LOW = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             commit,
   input  logic             duty_wr,
   input  logic [CNT_W-1:0] duty_in,
   input  logic [CNT_W-1:0] cnt,
   output logic             pwm_out
);

   localparam logic IDLE = idle_level(ACTIVE_LOW);

   logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
   logic [CNT_W-1:0] duty_act_q, duty_act_d;
   logic             pwm_q, pwm_d;

   // Commit copies the pre-write shadow, so a write in the commit cycle waits.
   always_comb begin
      duty_sh_d  = duty_wr ? duty_in : duty_sh_q;
      duty_act_d = commit ? duty_sh_q : duty_act_q;
      pwm_d      = enable ? ((cnt < duty_act_q) ^ IDLE) : IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         duty_sh_q  <= '0;
         duty_act_q <= '0;
         pwm_q      <= IDLE;
      end else begin
         duty_sh_q  <= duty_sh_d;
         duty_act_q <= duty_act_d;
         pwm_q      <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM generator: one shared period counter, NUM_CH duty comparators,
// double-buffered period/duty with boundary commit. Define PWM_CENTER_ALIGN_EN for up/down counting.
module pwm_multi_generator
   import pwm_pkg::*;
#(
   parameter int  NUM_CH         = 4,
   parameter int  CNT_W          = 16,
   parameter int  DEFAULT_PERIOD = 255,
   parameter int  ACTIVE_LOW     = 0,
   localparam int CH_W           = ch_width(NUM_CH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
`ifdef PWM_CENTER_ALIGN_EN
   input  logic              center_mode,
`endif
   input  logic              period_wr,
   input  logic [CNT_W-1:0]  period_in,
   input  logic              duty_wr,
   input  logic [CH_W-1:0]   duty_ch,
   input  logic [CNT_W-1:0]  duty_in,
   input  logic              update_req,
   output logic              update_pending,
   output logic              period_start,
   output logic [NUM_CH-1:0] pwm_out
);

   localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_act_q, period_act_d;
   logic [CNT_W-1:0] period_sh_q, period_sh_d;
   logic             pending_q, pending_d;
   logic             period_start_q, period_start_d;
   logic             enable_q, enable_d;
   logic             last_cycle, commit;
`ifdef PWM_CENTER_ALIGN_EN
   cnt_dir_t         dir_q, dir_d;
   logic             center_q, center_d;
   logic             center_run;
`endif

   always_comb begin
      period_sh_d = period_wr ? period_in : period_sh_q;
      enable_d    = enable;
`ifdef PWM_CENTER_ALIGN_EN
      center_run = center_q && (period_act_q != '0);
      if (center_run)
         last_cycle = enable && ((dir_q == CNT_DOWN) ? (cnt_q == ONE)
                                                     : (cnt_q >= period_act_q && period_act_q == ONE));
      else
         last_cycle = enable && (cnt_q >= period_act_q);
`else
      last_cycle = enable && (cnt_q >= period_act_q);
`endif
      // Disabling applies an armed commit at once instead of waiting for a boundary.
      commit         = pending_q && (last_cycle || !enable);
      pending_d      = commit ? 1'b0 : (update_req ? 1'b1 : pending_q);
      period_act_d   = commit ? period_sh_q : period_act_q;
      period_start_d = enable && (last_cycle || !enable_q);

      cnt_d = cnt_q + ONE;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d    = dir_q;
      center_d = center_q;
      if (!enable || last_cycle) begin
         cnt_d    = '0;
         dir_d    = CNT_UP;
         center_d = center_mode;
      end else if (center_run) begin
         if (dir_q == CNT_DOWN) begin
            cnt_d = cnt_q - ONE;
         end else if (cnt_q >= period_act_q) begin
            cnt_d = cnt_q - ONE;
            dir_d = CNT_DOWN;
         end
      end
`else
      if (!enable || last_cycle)
         cnt_d = '0;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q          <= '0;
         period_act_q   <= RST_PERIOD;
         period_sh_q    <= RST_PERIOD;
         pending_q      <= 1'b0;
         period_start_q <= 1'b0;
         enable_q       <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         dir_q          <= CNT_UP;
         center_q       <= 1'b0;
`endif
      end else begin
         cnt_q          <= cnt_d;
         period_act_q   <= period_act_d;
         period_sh_q    <= period_sh_d;
         pending_q      <= pending_d;
         period_start_q <= period_start_d;
         enable_q       <= enable_d;
`ifdef PWM_CENTER_ALIGN_EN
         dir_q          <= dir_d;
         center_q       <= center_d;
`endif
      end
   end

   assign update_pending = pending_q;
   assign period_start   = period_start_q;

   // Out-of-range channel indices match no instance, so those writes are dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pwm_channel_cmp #(
         .CNT_W      (CNT_W),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_cmp (
         .clock   (clock),
         .reset   (reset),
         .enable  (enable),
         .commit  (commit),
         .duty_wr (duty_wr && (duty_ch == CH_W'(i))),
         .duty_in (duty_in),
         .cnt     (cnt_q),
         .pwm_out (pwm_out[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Directed testbench for pwm_multi_generator: an active-high and an active-low
// instance share all inputs; outputs are sampled on the falling clock edge.
module tb_pwm_multi_generator;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;
   localparam int CH_W   = 2;

   logic              clock;
   logic              reset;
   logic              enable;
   logic              period_wr;
   logic [CNT_W-1:0]  period_in;
   logic              duty_wr;
   logic [CH_W-1:0]   duty_ch;
   logic [CNT_W-1:0]  duty_in;
   logic              update_req;
   logic              update_pending, update_pending_al;
   logic              period_start, period_start_al;
   logic [NUM_CH-1:0] pwm_out, pwm_out_al;
`ifdef PWM_CENTER_ALIGN_EN
   logic              center_mode;
`endif

   int                checkCount;
   int                passCount;
   int                hiCnt [NUM_CH];
   int                startMid, startEnd, pendCnt, pendEnd, waitCycles;
   logic [NUM_CH-1:0] firstPwm, firstPwmAl;

   pwm_multi_generator #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(255), .ACTIVE_LOW(0)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
`ifdef PWM_CENTER_ALIGN_EN
      .center_mode(center_mode),
`endif
      .period_wr(period_wr), .period_in(period_in),
      .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_in(duty_in),
      .update_req(update_req), .update_pending(update_pending),
      .period_start(period_start), .pwm_out(pwm_out)
   );

   pwm_multi_generator #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(255), .ACTIVE_LOW(1)
   ) dut_al (
      .clock(clock), .reset(reset), .enable(enable),
`ifdef PWM_CENTER_ALIGN_EN
      .center_mode(center_mode),
`endif
      .period_wr(period_wr), .period_in(period_in),
      .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_in(duty_in),
      .update_req(update_req), .update_pending(update_pending_al),
      .period_start(period_start_al), .pwm_out(pwm_out_al)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   // Drives one clock worth of register-interface strobes, then returns them to idle.
   task automatic applyStimulus(input logic pwr, input logic [7:0] pin, input logic dwr,
                                input logic [1:0] dch, input logic [7:0] din, input logic upd);
      period_wr  = pwr;
      period_in  = pin;
      duty_wr    = dwr;
      duty_ch    = dch;
      duty_in    = din;
      update_req = upd;
      step();
      period_wr  = 1'b0;
      duty_wr    = 1'b0;
      update_req = 1'b0;
   endtask

   task automatic waitForStart(input int bound);
      waitCycles = -1;
      for (int n = 1; n <= bound; n++) begin
         step();
         if (period_start) begin
            waitCycles = n;
            break;
         end
      end
   endtask

   // Runs len clocks from a period_start cycle, optionally writing a duty at
   // step wrIdx and pulsing update_req at step reqIdx, and tallies the outputs.
   task automatic runPeriod(input int len, input int wrIdx, input logic [1:0] wrCh,
                            input logic [7:0] wrVal, input int reqIdx);
      for (int c = 0; c < NUM_CH; c++) hiCnt[c] = 0;
      startMid = 0;
      pendCnt  = 0;
      for (int j = 1; j <= len; j++) begin
         duty_wr    = (j == wrIdx);
         duty_ch    = wrCh;
         duty_in    = wrVal;
         update_req = (j == reqIdx);
         step();
         duty_wr    = 1'b0;
         update_req = 1'b0;
         for (int c = 0; c < NUM_CH; c++) hiCnt[c] += int'(pwm_out[c]);
         if (j == 1) begin
            firstPwm   = pwm_out;
            firstPwmAl = pwm_out_al;
         end
         if (j < len) begin
            startMid += int'(period_start);
            pendCnt  += int'(update_pending);
         end
      end
      startEnd = int'(period_start);
      pendEnd  = int'(update_pending);
   endtask

   task automatic checkHigh(input string tag, input int e0, input int e1, input int e2, input int e3);
      int expHi [NUM_CH];
      expHi = '{e0, e1, e2, e3};
      for (int c = 0; c < NUM_CH; c++)
         checkOutput($sformatf("%s_hi_ch%0d", tag, c), hiCnt[c], expHi[c]);
      checkOutput({tag, "_mid_start"}, startMid, 0);
      checkOutput({tag, "_end_start"}, startEnd, 1);
   endtask

   initial begin
      int hiSeen, alBad, starts;
      checkCount = 0;
      passCount  = 0;
      reset      = 1'b1;
      enable     = 1'b0;
      period_wr  = 1'b0;
      period_in  = '0;
      duty_wr    = 1'b0;
      duty_ch    = '0;
      duty_in    = '0;
      update_req = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      center_mode = 1'b0;
`endif
      step();
      checkOutput("reset_pwm", 32'(pwm_out), 32'h0);
      checkOutput("reset_pwm_al", 32'(pwm_out_al), 32'hF);
      checkOutput("reset_pending", 32'(update_pending), 0);
      checkOutput("reset_start", 32'(period_start), 0);
      checkOutput("reset_pending_al", 32'(update_pending_al), 0);
      checkOutput("reset_start_al", 32'(period_start_al), 0);
      reset = 1'b0;

      // Default period 255 with zero duties: idle outputs, starts at enable and two boundaries.
      enable = 1'b1;
      hiSeen = 0;
      alBad  = 0;
      starts = 0;
      for (int k = 0; k < 600; k++) begin
         step();
         if (pwm_out != 4'h0) hiSeen++;
         if (pwm_out_al != 4'hF) alBad++;
         starts += int'(period_start);
      end
      checkOutput("idle_high_cycles", hiSeen, 0);
      checkOutput("idle_al_cycles", alBad, 0);
      checkOutput("idle_starts", starts, 3);

      // P=9 with duties {0,3,5,12} committed at the next boundary.
      applyStimulus(1'b1, 8'd9, 1'b1, 2'd0, 8'd0, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b1, 2'd1, 8'd3, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b1, 2'd2, 8'd5, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b1, 2'd3, 8'd12, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 1'b1);
      checkOutput("arm_pending", 32'(update_pending), 1);
      waitForStart(300);
      checkOutput("first_boundary_wait", waitCycles, 163);
      checkOutput("boundary_pwm", 32'(pwm_out), 32'h0);
      runPeriod(10, 0, 2'd0, 8'd0, 0);
      checkOutput("p9_first_pwm", 32'(firstPwm), 32'hE);
      checkOutput("p9_first_pwm_al", 32'(firstPwmAl), 32'h1);
      checkHigh("p9", 0, 3, 5, 10);

      // Mid-period ch1 write and request at cnt=4: current period unchanged.
      runPeriod(10, 2, 2'd1, 8'd7, 5);
      checkHigh("mid_req", 0, 3, 5, 10);
      checkOutput("mid_req_pend_cnt", pendCnt, 5);
      checkOutput("mid_req_pend_end", pendEnd, 0);
      runPeriod(10, 0, 2'd0, 8'd0, 0);
      checkHigh("mid_req_next", 0, 7, 5, 10);

      // Request in the last cycle lands one full period later.
      runPeriod(10, 2, 2'd2, 8'd2, 10);
      checkHigh("late_req", 0, 7, 5, 10);
      checkOutput("late_req_pend_cnt", pendCnt, 0);
      checkOutput("late_req_pend_end", pendEnd, 1);
      runPeriod(10, 0, 2'd0, 8'd0, 0);
      checkHigh("late_req_wait", 0, 7, 5, 10);
      checkOutput("late_wait_pend_cnt", pendCnt, 9);
      checkOutput("late_wait_pend_end", pendEnd, 0);
      runPeriod(10, 0, 2'd0, 8'd0, 0);
      checkHigh("late_req_done", 0, 7, 2, 10);

      // Disable with a commit pending applies it immediately.
      applyStimulus(1'b0, 8'd0, 1'b1, 2'd3, 8'd4, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 1'b1);
      checkOutput("dis_pending_before", 32'(update_pending), 1);
      enable = 1'b0;
      step();
      checkOutput("dis_pwm", 32'(pwm_out), 32'h0);
      checkOutput("dis_pwm_al", 32'(pwm_out_al), 32'hF);
      checkOutput("dis_pending", 32'(update_pending), 0);
      checkOutput("dis_start", 32'(period_start), 0);
      step();
      checkOutput("dis_hold_pwm", 32'(pwm_out), 32'h0);
      enable = 1'b1;
      step();
      checkOutput("reen_start", 32'(period_start), 1);
      checkOutput("reen_pwm", 32'(pwm_out), 32'hE);
      waitForStart(20);
      checkOutput("reen_boundary_wait", waitCycles, 9);
      runPeriod(10, 0, 2'd0, 8'd0, 0);
      checkHigh("reen", 0, 7, 2, 4);

      // Asynchronous reset at cnt=5 with ch1 high.
      repeat (5) step();
      checkOutput("pre_rst_pwm", 32'(pwm_out), 32'h2);
      checkOutput("pre_rst_pwm_al", 32'(pwm_out_al), 32'hD);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_pwm", 32'(pwm_out), 32'h0);
      checkOutput("async_rst_pwm_al", 32'(pwm_out_al), 32'hF);
      checkOutput("async_rst_pending", 32'(update_pending), 0);
      checkOutput("async_rst_start", 32'(period_start), 0);
      step();
      reset = 1'b0;

`ifdef PWM_CENTER_ALIGN_EN
      // Centre-aligned: P=8, D=3 gives a 16-clock period with 5 high clocks.
      center_mode = 1'b1;
      enable      = 1'b0;
      applyStimulus(1'b1, 8'd8, 1'b1, 2'd0, 8'd3, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 1'b1);
      checkOutput("ctr_pending", 32'(update_pending), 1);
      step();
      checkOutput("ctr_commit", 32'(update_pending), 0);
      enable = 1'b1;
      step();
      checkOutput("ctr_reen_start", 32'(period_start), 1);
      checkOutput("ctr_reen_pwm", 32'(pwm_out), 32'h1);
      waitForStart(40);
      checkOutput("ctr_boundary_wait", waitCycles, 15);
      runPeriod(16, 0, 2'd0, 8'd0, 0);
      checkHigh("ctr", 5, 0, 0, 0);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
